// File: rtl/pc_gen.sv
// Program-counter generator for the fetch stage.
// Holds the word-aligned PC and picks the next PC from exception, ERET, redirect,
// call/return (through a circular return-address stack) or sequential sources.
// Also holds the EPC register.
module pc_gen #(
  parameter int                ADDR_W    = 32,
  parameter logic [ADDR_W-1:0] RESET_VEC = 32'h0000_3000,
  parameter logic [ADDR_W-1:0] EXC_VEC   = 32'h0000_4180,
  parameter int                RAS_DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         pc_write,
  input  logic                         redirect_valid,
  input  logic [ADDR_W-3:0]            redirect_target,
  input  logic                         exc_valid,
  input  logic [ADDR_W-3:0]            exc_pc,
  input  logic                         eret,
  input  logic                         call,
  input  logic [ADDR_W-3:0]            call_target,
  input  logic                         ret,
  input  logic [ADDR_W-3:0]            ret_target,
  output logic [ADDR_W-3:0]            pc,
  output logic [ADDR_W-3:0]            epc,
  output logic [$clog2(RAS_DEPTH):0]   ras_count,
  output logic                         ras_underflow
);

  localparam int WA = ADDR_W - 2;
  localparam int PW = $clog2(RAS_DEPTH);
  localparam int CW = PW + 1;

  localparam logic [WA-1:0] RESET_WORD = RESET_VEC[ADDR_W-1:2];
  localparam logic [WA-1:0] EXC_WORD   = EXC_VEC[ADDR_W-1:2];
  localparam logic [CW-1:0] RAS_FULL   = CW'(RAS_DEPTH);

  logic [WA-1:0] r_pc;
  logic [WA-1:0] r_epc;
  logic [CW-1:0] r_cnt;
  logic [PW-1:0] r_tp;
  logic          r_uf;
  logic [WA-1:0] r_ras [RAS_DEPTH];

  logic [WA-1:0] w_pc_inc;
  logic [WA-1:0] w_pc_nxt;
  logic [WA-1:0] w_epc_nxt;
  logic [CW-1:0] w_cnt_nxt;
  logic [PW-1:0] w_tp_nxt;
  logic          w_uf_nxt;
  logic          w_ras_we;
  logic [PW-1:0] w_ras_wa;

  // Sequential successor wraps modulo 2^WA by construction.
  assign w_pc_inc = r_pc + WA'(1);

  // Priority arbitration: exactly one source wins; losers have no side effect.
  always_comb begin
    w_pc_nxt  = w_pc_inc;
    w_epc_nxt = r_epc;
    w_cnt_nxt = r_cnt;
    w_tp_nxt  = r_tp;
    w_uf_nxt  = 1'b0;
    w_ras_we  = 1'b0;
    w_ras_wa  = r_tp;
    if (exc_valid) begin
      // Flush only clears the count; stale entries are never read again.
      w_pc_nxt  = EXC_WORD;
      w_epc_nxt = exc_pc;
      w_cnt_nxt = '0;
    end else if (eret) begin
      w_pc_nxt = r_epc;
    end else if (redirect_valid) begin
      w_pc_nxt = redirect_target;
    end else if (!pc_write) begin
      w_pc_nxt = r_pc;
    end else if (call && ret) begin
      // Pop+push collapses into overwriting the top in place.
      w_pc_nxt = call_target;
      w_ras_we = 1'b1;
      w_ras_wa = r_tp;
      if (r_cnt == '0) w_cnt_nxt = CW'(1);
    end else if (call) begin
      // Full stack: pointer still advances, overwriting the oldest entry.
      w_pc_nxt = call_target;
      w_ras_we = 1'b1;
      w_ras_wa = r_tp + PW'(1);
      w_tp_nxt = r_tp + PW'(1);
      if (r_cnt != RAS_FULL) w_cnt_nxt = r_cnt + CW'(1);
    end else if (ret) begin
      if (r_cnt != '0) begin
        w_pc_nxt  = r_ras[r_tp];
        w_tp_nxt  = r_tp - PW'(1);
        w_cnt_nxt = r_cnt - CW'(1);
      end else begin
        w_pc_nxt = ret_target;
        w_uf_nxt = 1'b1;
      end
    end
  end

  // Control and architectural state, asynchronously reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pc  <= RESET_WORD;
      r_epc <= '0;
      r_cnt <= '0;
      r_tp  <= '0;
      r_uf  <= 1'b0;
    end else begin
      r_pc  <= w_pc_nxt;
      r_epc <= w_epc_nxt;
      r_cnt <= w_cnt_nxt;
      r_tp  <= w_tp_nxt;
      r_uf  <= w_uf_nxt;
    end
  end

  // RAS storage: data only, validity is tracked by r_cnt.
  always_ff @(posedge clk) begin
    if (rst_n && w_ras_we) r_ras[w_ras_wa] <= w_pc_inc;
  end

  assign pc            = r_pc;
  assign epc           = r_epc;
  assign ras_count     = r_cnt;
  assign ras_underflow = r_uf;

endmodule

// File: tb/tb_pc_gen.sv
// Directed, table-driven bench for pc_gen (default parameters).
module tb_pc_gen;

  localparam int WA = 30;

  typedef struct {
    logic          pw;
    logic          rdv;
    logic [WA-1:0] rdt;
    logic          exv;
    logic [WA-1:0] exp;
    logic          er;
    logic          ca;
    logic [WA-1:0] ct;
    logic          re;
    logic [WA-1:0] rt;
    logic [WA-1:0] e_pc;
    logic [WA-1:0] e_epc;
    logic [2:0]    e_cnt;
    logic          e_uf;
  } vec_t;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          pc_write = 1'b0;
  logic          redirect_valid = 1'b0;
  logic [WA-1:0] redirect_target = '0;
  logic          exc_valid = 1'b0;
  logic [WA-1:0] exc_pc = '0;
  logic          eret = 1'b0;
  logic          call = 1'b0;
  logic [WA-1:0] call_target = '0;
  logic          ret = 1'b0;
  logic [WA-1:0] ret_target = '0;
  logic [WA-1:0] pc;
  logic [WA-1:0] epc;
  logic [2:0]    ras_count;
  logic          ras_underflow;

  int errors = 0;
  int checks = 0;
  vec_t tbl[$];

  pc_gen dut (
    .clk(clk), .rst_n(rst_n), .pc_write(pc_write),
    .redirect_valid(redirect_valid), .redirect_target(redirect_target),
    .exc_valid(exc_valid), .exc_pc(exc_pc), .eret(eret),
    .call(call), .call_target(call_target), .ret(ret), .ret_target(ret_target),
    .pc(pc), .epc(epc), .ras_count(ras_count), .ras_underflow(ras_underflow)
  );

  always #5 clk = ~clk;

  function automatic vec_t mk(logic pw, logic rdv, logic [WA-1:0] rdt, logic exv,
                              logic [WA-1:0] exp, logic er, logic ca, logic [WA-1:0] ct,
                              logic re, logic [WA-1:0] rt, logic [WA-1:0] e_pc,
                              logic [WA-1:0] e_epc, logic [2:0] e_cnt, logic e_uf);
    vec_t v;
    v.pw = pw; v.rdv = rdv; v.rdt = rdt; v.exv = exv; v.exp = exp; v.er = er;
    v.ca = ca; v.ct = ct; v.re = re; v.rt = rt;
    v.e_pc = e_pc; v.e_epc = e_epc; v.e_cnt = e_cnt; v.e_uf = e_uf;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h, want %h", name, act, req);
    end
  endtask

  task automatic check_all(input string tag, input logic [WA-1:0] e_pc,
                           input logic [WA-1:0] e_epc, input logic [2:0] e_cnt, input logic e_uf);
    chk({tag, " pc"}, 32'(pc), 32'(e_pc));
    chk({tag, " epc"}, 32'(epc), 32'(e_epc));
    chk({tag, " ras_count"}, 32'(ras_count), 32'(e_cnt));
    chk({tag, " ras_underflow"}, 32'(ras_underflow), 32'(e_uf));
  endtask

  task automatic drive(input vec_t v);
    pc_write = v.pw; redirect_valid = v.rdv; redirect_target = v.rdt;
    exc_valid = v.exv; exc_pc = v.exp; eret = v.er;
    call = v.ca; call_target = v.ct; ret = v.re; ret_target = v.rt;
  endtask

  initial begin
    vec_t idle;
    idle = mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

    //        pw rdv rdt           exv exp      er ca ct       re rt        pc            epc      cnt uf
    // stall vs redirect
    tbl.push_back(mk(1, 0, 0,            0, 0,      0, 0, 0,       0, 0,       30'h0C01,     0,       0, 0));
    tbl.push_back(mk(1, 0, 0,            0, 0,      0, 0, 0,       0, 0,       30'h0C02,     0,       0, 0));
    tbl.push_back(mk(0, 0, 0,            0, 0,      0, 0, 0,       0, 0,       30'h0C02,     0,       0, 0));
    tbl.push_back(mk(0, 0, 0,            0, 0,      0, 0, 0,       0, 0,       30'h0C02,     0,       0, 0));
    tbl.push_back(mk(0, 1, 30'h1000,     0, 0,      0, 0, 0,       0, 0,       30'h1000,     0,       0, 0));
    tbl.push_back(mk(0, 0, 0,            0, 0,      0, 1, 30'h7777,0, 0,       30'h1000,     0,       0, 0));
    tbl.push_back(mk(0, 0, 0,            0, 0,      0, 0, 0,       1, 30'h5555,30'h1000,     0,       0, 0));
    // basic call / return
    tbl.push_back(mk(1, 1, 30'h0C05,     0, 0,      0, 0, 0,       0, 0,       30'h0C05,     0,       0, 0));
    tbl.push_back(mk(1, 0, 0,            0, 0,      0, 1, 30'h2000,0, 0,       30'h2000,     0,       1, 0));
    tbl.push_back(mk(1, 0, 0,            0, 0,      0, 0, 0,       1, 0,       30'h0C06,     0,       0, 0));
    // five calls into a four-deep stack, then five returns
    tbl.push_back(mk(1, 0, 0,            0, 0,      0, 1, 30'h3000,0, 0,       30'h3000,     0,       1, 0));
    tbl.push_back(mk(1, 0, 0,            0, 0,      0, 1, 30'h3100,0, 0,       30'h3100,     0,       2, 0));
    tbl.push_back(mk(1, 0, 0,            0, 0,      0, 1, 30'h3200,0, 0,       30'h3200,     0,       3, 0));
    tbl.push_back(mk(1, 0, 0,            0, 0,      0, 1, 30'h3300,0, 0,       30'h3300,     0,       4, 0));
    tbl.push_back(mk(1, 0, 0,            0, 0,      0, 1, 30'h3400,0, 0,       30'h3400,     0,       4, 0));
    tbl.push_back(mk(1, 0, 0,            0, 0,      0, 0, 0,       1, 0,       30'h3301,     0,       3, 0));
    tbl.push_back(mk(1, 0, 0,            0, 0,      0, 0, 0,       1, 0,       30'h3201,     0,       2, 0));
    tbl.push_back(mk(1, 0, 0,            0, 0,      0, 0, 0,       1, 0,       30'h3101,     0,       1, 0));
    tbl.push_back(mk(1, 0, 0,            0, 0,      0, 0, 0,       1, 0,       30'h3001,     0,       0, 0));
    tbl.push_back(mk(1, 0, 0,            0, 0,      0, 0, 0,       1, 30'h0777,30'h0777,     0,       0, 1));
    tbl.push_back(mk(1, 0, 0,            0, 0,      0, 0, 0,       0, 0,       30'h0778,     0,       0, 0));
    // exception beats redirect and call, flushes RAS; eret beats redirect
    tbl.push_back(mk(1, 0, 0,            0, 0,      0, 1, 30'h4000,0, 0,       30'h4000,     0,       1, 0));
    tbl.push_back(mk(1, 1, 30'h1234,     1, 30'h0D00,0, 1, 30'h5000,0, 0,      30'h1060,     30'h0D00,0, 0));
    tbl.push_back(mk(1, 0, 0,            0, 0,      0, 0, 0,       0, 0,       30'h1061,     30'h0D00,0, 0));
    tbl.push_back(mk(1, 1, 30'h1234,     0, 0,      1, 0, 0,       0, 0,       30'h0D00,     30'h0D00,0, 0));
    // call and ret together replace the top
    tbl.push_back(mk(1, 0, 0,            0, 0,      0, 1, 30'h6000,0, 0,       30'h6000,     30'h0D00,1, 0));
    tbl.push_back(mk(1, 0, 0,            0, 0,      0, 1, 30'h6100,1, 30'h0999,30'h6100,     30'h0D00,1, 0));
    tbl.push_back(mk(1, 0, 0,            0, 0,      0, 0, 0,       1, 0,       30'h6001,     30'h0D00,0, 0));
    // exception beats eret
    tbl.push_back(mk(1, 0, 0,            1, 30'h0E00,1, 0, 0,       0, 0,       30'h1060,     30'h0E00,0, 0));
    // wrap
    tbl.push_back(mk(1, 1, 30'h3FFF_FFFF,0, 0,      0, 0, 0,       0, 0,       30'h3FFF_FFFF,30'h0E00,0, 0));
    tbl.push_back(mk(1, 0, 0,            0, 0,      0, 0, 0,       0, 0,       30'h0000,     30'h0E00,0, 0));
    tbl.push_back(mk(1, 0, 0,            0, 0,      0, 0, 0,       0, 0,       30'h0001,     30'h0E00,0, 0));
    // eret applies even while stalled
    tbl.push_back(mk(0, 0, 0,            0, 0,      1, 0, 0,       0, 0,       30'h0E00,     30'h0E00,0, 0));

    // Power-on reset
    drive(idle);
    repeat (2) @(negedge clk);
    check_all("por", 30'h0C00, 0, 0, 0);
    rst_n = 1'b1;

    foreach (tbl[i]) begin
      drive(tbl[i]);
      @(posedge clk);
      #1;
      check_all($sformatf("vec%0d", i), tbl[i].e_pc, tbl[i].e_epc, tbl[i].e_cnt, tbl[i].e_uf);
      @(negedge clk);
    end

    // Underflow pulse, then async reset with a call pending and no clock edge
    drive(mk(1, 0, 0, 0, 0, 0, 0, 0, 1, 30'h0123, 0, 0, 0, 0));
    @(posedge clk);
    #1;
    check_all("uf", 30'h0123, 30'h0E00, 0, 1);
    drive(mk(1, 0, 0, 0, 0, 0, 1, 30'h2222, 0, 0, 0, 0, 0, 0));
    #1;
    rst_n = 1'b0;
    #1;
    check_all("async_rst", 30'h0C00, 0, 0, 0);
    @(negedge clk);
    drive(idle);
    rst_n = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      @(posedge clk);
      #1;
      check_all($sformatf("post_rst%0d", k), 30'h0C00 + 30'(k), 0, 0, 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
